// File: rtl/quad_decoder_pkg.sv
// Shared definitions for the quadrature decoder and its downstream pixel counter.
package quad_pkg;

  // Step commands understood by the downstream pixel counter.
  localparam logic [1:0] MOVE_IDLE = 2'b00;
  localparam logic [1:0] MOVE_INC  = 2'b10;
  localparam logic [1:0] MOVE_DEC  = 2'b01;

  // Classification of one change of the filtered {a, b} pair.
  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_CW,
    STEP_CCW,
    STEP_ILLEGAL
  } step_t;

  // Direction of the partially accumulated detent.
  typedef enum logic {
    DIR_POS,
    DIR_NEG
  } dir_t;

  // Gray-code successor in the clockwise sequence 00->01->11->10->00.
  function automatic logic [1:0] cw_next(input logic [1:0] s);
    return {s[0], ~s[1]};
  endfunction

  // Gray-code successor in the counter-clockwise sequence 00->10->11->01->00.
  function automatic logic [1:0] ccw_next(input logic [1:0] s);
    return {~s[0], s[1]};
  endfunction

  // A one-bit change is a step whose direction follows the gray order;
  // a two-bit change cannot be attributed to either direction.
  function automatic step_t classify_step(input logic [1:0] prev,
                                          input logic [1:0] curr);
    step_t cls;
    if (curr == prev)
      cls = STEP_NONE;
    else if (curr == cw_next(prev))
      cls = STEP_CW;
    else if (curr == ccw_next(prev))
      cls = STEP_CCW;
    else
      cls = STEP_ILLEGAL;
    return cls;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder-side bundle: raw channels in, step/error reporting out.
interface quad_decoder_if;
  logic       enc_a;
  logic       enc_b;
  logic [1:0] move;
  logic       err;
  logic [7:0] err_cnt;

  // Encoder/stimulus side.
  modport master (output enc_a, output enc_b,
                  input  move,  input  err, input err_cnt);

  // Decoder side.
  modport slave  (input  enc_a, input  enc_b,
                  output move,  output err, output err_cnt);
endinterface

// File: rtl/quad_decoder_debounce_filter.sv
// Per-channel 2-flop synchroniser followed by a level debounce filter.
// The filtered output follows the synchronised input only after the
// input has differed from it for DEBOUNCE consecutive clk cycles.
module debounce_filter #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  // Counter compare value; the filtered level flips on the cycle the
  // count of differing samples reaches DEBOUNCE.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;

  // Bring the asynchronous encoder level into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync2 == filt) begin
      cnt  <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      filt <= sync2;
    end else begin
      cnt  <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: debounces both channels, classifies each
// change of the filtered pair, accumulates same-direction steps and emits
// one move command per detent. Illegal two-bit changes are flagged and
// counted (saturating at 255).
module quad_decoder #(
  parameter int DEBOUNCE         = 4,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  quad_decoder_if.slave  bus
);
  import quad_pkg::*;

  localparam logic [2:0] DETENT = 3'(STEPS_PER_DETENT);

  logic       filt_a;
  logic       filt_b;
  logic [1:0] quad_prev;
  step_t      step_q;
  dir_t       dir;
  logic [2:0] mag;
  dir_t       step_dir;
  logic [2:0] mag_next;
  logic [1:0] move_r;
  logic       err_r;
  logic [7:0] err_cnt_r;

  debounce_filter #(.DEBOUNCE(DEBOUNCE)) u_filt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.enc_a),
    .filt  (filt_a)
  );

  debounce_filter #(.DEBOUNCE(DEBOUNCE)) u_filt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.enc_b),
    .filt  (filt_b)
  );

  // Classify each change of the filtered pair and register the result, so
  // the accumulator sees one clean step class per cycle with no dead cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quad_prev <= 2'b00;
      step_q    <= STEP_NONE;
    end else begin
      quad_prev <= {filt_a, filt_b};
      step_q    <= classify_step(quad_prev, {filt_a, filt_b});
    end
  end

  // Magnitude after this step: grows when continuing (or starting from
  // zero), restarts at one when the direction reverses.
  always_comb begin
    step_dir = (step_q == STEP_CCW) ? DIR_NEG : DIR_POS;
    mag_next = ((mag == 3'd0) || (dir == step_dir)) ? mag + 3'd1 : 3'd1;
  end

  // Accumulate steps, emit one move per detent, and flag illegal changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir       <= DIR_POS;
      mag       <= '0;
      move_r    <= MOVE_IDLE;
      err_r     <= 1'b0;
      err_cnt_r <= '0;
    end else begin
      move_r <= MOVE_IDLE;
      err_r  <= 1'b0;
      unique case (step_q)
        STEP_CW, STEP_CCW: begin
          dir <= step_dir;
          if (mag_next == DETENT) begin
            mag    <= '0;
            move_r <= (step_dir == DIR_POS) ? MOVE_INC : MOVE_DEC;
          end else begin
            mag <= mag_next;
          end
        end
        STEP_ILLEGAL: begin
          mag   <= '0;
          err_r <= 1'b1;
          if (err_cnt_r != 8'hFF)
            err_cnt_r <= err_cnt_r + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.move    = move_r;
  assign bus.err     = err_r;
  assign bus.err_cnt = err_cnt_r;

endmodule
